// File: rtl/note_seq_pkg.sv
// Shared types and constants for the melody sequencer: FSM states, 12 MHz note
// half-period divisors and duration tick constants.
package note_seq_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StPlay
  } state_e;

  // Half-period divisors in 12 MHz clock cycles (12e6 / (2 * f_note)), octave 4
  localparam int unsigned DO_4  = 22933;
  localparam int unsigned RE_4  = 20431;
  localparam int unsigned MI_4  = 18202;
  localparam int unsigned FA_4  = 17181;
  localparam int unsigned SOL_4 = 15306;
  localparam int unsigned LA_4  = 13636;
  localparam int unsigned SI_4  = 12148;

  localparam int unsigned T_10ms = 120000;  // clk cycles per 10 ms duration tick
  localparam int unsigned T_1s   = 100;     // ticks per second

endpackage

// File: rtl/note_tone.sv
// Square-wave tone generator: half-period counter latched on load, div==0 is a rest.
module note_tone #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             ch_out
);

  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] r_cnt;
  logic             r_out;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_div <= '0;
      r_cnt <= '0;
      r_out <= 1'b0;
    end else if (load) begin
      r_div <= div;
      r_cnt <= (div == '0) ? '0 : div - 1'b1;
      r_out <= 1'b0;
    end else if (!en) begin
      r_out <= 1'b0;
    end else if (r_div != '0) begin
      if (r_cnt == '0) begin
        r_out <= ~r_out;
        r_cnt <= r_div - 1'b1;
      end else begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  assign ch_out = r_out;

endmodule

// File: rtl/note_seq.sv
// Programmable melody sequencer: note table, duration prescaler and playback FSM.
// Optional looping at table wrap is enabled by defining NOTE_SEQ_LOOP_EN.
module note_seq
  import note_seq_pkg::*;
#(
  parameter int unsigned NUM_NOTES = 8,
  parameter int unsigned DIV_W     = 16,
  parameter int unsigned DUR_W     = 8,
  parameter int unsigned TICK_DIV  = 120000
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         start,
  input  logic                         stop,
  input  logic                         wr_en,
  input  logic [$clog2(NUM_NOTES)-1:0] wr_addr,
  input  logic [DIV_W-1:0]             wr_div,
  input  logic [DUR_W-1:0]             wr_dur,
`ifdef NOTE_SEQ_LOOP_EN
  input  logic                         loop,
`endif
  output logic                         ch_out,
  output logic                         busy,
  output logic                         done,
  output logic [$clog2(NUM_NOTES)-1:0] idx
);

  localparam int unsigned AW    = $clog2(NUM_NOTES);
  localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [AW-1:0]    LAST_IDX = AW'(NUM_NOTES - 1);
  localparam logic [PRE_W-1:0] PRE_TOP  = PRE_W'(TICK_DIV - 1);

  logic [DIV_W-1:0] r_tab_div [NUM_NOTES];
  logic [DUR_W-1:0] r_tab_dur [NUM_NOTES];

  state_e           r_state;
  logic [AW-1:0]    r_idx;
  logic [PRE_W-1:0] r_pre;
  logic [DUR_W-1:0] r_dur_cnt;
  logic             r_busy;
  logic             r_done;

  logic [DIV_W-1:0] w_rd_div;
  logic [DUR_W-1:0] w_rd_dur;
  logic             w_note_end;
  logic             w_loop;
  logic             w_tone_load;
  logic             w_tone_en;

`ifdef NOTE_SEQ_LOOP_EN
  assign w_loop = loop;
`else
  assign w_loop = 1'b0;
`endif

  assign w_rd_div    = r_tab_div[r_idx];
  assign w_rd_dur    = r_tab_dur[r_idx];
  assign w_note_end  = (r_state == StPlay) && (r_pre == '0) && (r_dur_cnt == DUR_W'(1));
  assign w_tone_load = (r_state == StLoad);
  // Tone output is forced low on the edge that leaves PLAY for any reason
  assign w_tone_en   = (r_state == StPlay) && !stop && !w_note_end;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_NOTES; i++) begin
        r_tab_div[i] <= '0;
        r_tab_dur[i] <= '0;
      end
    end else if (wr_en && (r_state == StIdle)) begin
      r_tab_div[wr_addr] <= wr_div;
      r_tab_dur[wr_addr] <= wr_dur;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= StIdle;
      r_idx     <= '0;
      r_pre     <= '0;
      r_dur_cnt <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (start && !stop) begin
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_state <= StLoad;
          end
        end
        StLoad: begin
          if (stop) begin
            r_busy  <= 1'b0;
            r_state <= StIdle;
          end else if (w_rd_dur == '0) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= StIdle;
          end else begin
            r_pre     <= PRE_TOP;
            r_dur_cnt <= w_rd_dur;
            r_state   <= StPlay;
          end
        end
        StPlay: begin
          if (stop) begin
            r_busy  <= 1'b0;
            r_state <= StIdle;
          end else begin
            if (r_pre == '0) begin
              r_pre     <= PRE_TOP;
              r_dur_cnt <= r_dur_cnt - 1'b1;
            end else begin
              r_pre <= r_pre - 1'b1;
            end
            if (w_note_end) begin
              if (r_idx != LAST_IDX) begin
                r_idx   <= r_idx + 1'b1;
                r_state <= StLoad;
              end else if (w_loop) begin
                r_idx   <= '0;
                r_state <= StLoad;
              end else begin
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_state <= StIdle;
              end
            end
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
      endcase
    end
  end

  note_tone #(
    .DIV_W(DIV_W)
  ) u_tone (
    .clk    (clk),
    .rstn   (rstn),
    .load   (w_tone_load),
    .en     (w_tone_en),
    .div    (w_rd_div),
    .ch_out (ch_out)
  );

  assign busy = r_busy;
  assign done = r_done;
  assign idx  = r_idx;

endmodule

// File: tb/tb_note_seq.sv
// Bench for note_seq: cycle traces predicted from the note table by a behavioural
// model, plus directed reset/stop/guard scenarios. Loop cases need NOTE_SEQ_LOOP_EN.
module tb_note_seq;

  localparam int unsigned N  = 4;
  localparam int unsigned TD = 4;
  localparam int unsigned AW = 2;
  localparam int unsigned DV = 6;
  localparam int unsigned DR = 4;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DV-1:0] wr_div = '0;
  logic [DR-1:0] wr_dur = '0;
  logic          loop_drv = 1'b0;
  logic          ch_out;
  logic          busy;
  logic          done;
  logic [AW-1:0] idx;

  int n_checks = 0;
  int n_errors = 0;

  int m_div [N];
  int m_dur [N];
  logic [AW+2:0] exp_q [$];
  int last_pass_start;

  always #5 clk = ~clk;

  note_seq #(
    .NUM_NOTES (N),
    .DIV_W     (DV),
    .DUR_W     (DR),
    .TICK_DIV  (TD)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .start   (start),
    .stop    (stop),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_div  (wr_div),
    .wr_dur  (wr_dur),
`ifdef NOTE_SEQ_LOOP_EN
    .loop    (loop_drv),
`endif
    .ch_out  (ch_out),
    .busy    (busy),
    .done    (done),
    .idx     (idx)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Writes go to both the DUT (in IDLE) and the model table
  task automatic wr(input int a, input int d, input int u);
    wr_en   = 1'b1;
    wr_addr = AW'(a);
    wr_div  = DV'(d);
    wr_dur  = DR'(u);
    m_div[a] = d;
    m_dur[a] = u;
    @(posedge clk);
    #1 wr_en = 1'b0;
  endtask

  // Expected {busy,done,ch_out,idx} for each cycle after the start edge
  task automatic build(input int passes);
    exp_q.delete();
    last_pass_start = 0;
    for (int p = 0; p < passes; p++) begin
      if (p == passes - 1) last_pass_start = exp_q.size();
      for (int i = 0; i < N; i++) begin
        exp_q.push_back({1'b1, 1'b0, 1'b0, AW'(i)});
        if (m_dur[i] == 0) begin
          exp_q.push_back({1'b0, 1'b1, 1'b0, AW'(i)});
          exp_q.push_back({1'b0, 1'b0, 1'b0, AW'(i)});
          return;
        end
        for (int k = 0; k < m_dur[i] * TD; k++) begin
          exp_q.push_back({1'b1, 1'b0, (m_div[i] == 0) ? 1'b0 : 1'((k / m_div[i]) % 2), AW'(i)});
        end
      end
    end
    exp_q.push_back({1'b0, 1'b1, 1'b0, AW'(N - 1)});
    exp_q.push_back({1'b0, 1'b0, 1'b0, AW'(N - 1)});
  endtask

  // inject_at >= 0: pulse start and a table write in that busy cycle (both must be ignored)
  task automatic run_trace(input string name, input int passes, input int inject_at);
    logic [AW+2:0] o;
    build(passes);
    loop_drv = (passes > 1);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 0; c < exp_q.size(); c++) begin
      if (c == inject_at) begin
        start   = 1'b1;
        wr_en   = 1'b1;
        wr_addr = '0;
        wr_div  = DV'(5);
        wr_dur  = DR'(7);
      end
      if (passes > 1 && c == last_pass_start) loop_drv = 1'b0;
      @(negedge clk);
      o = {busy, done, ch_out, idx};
      chk($sformatf("%s c%0d {busy,done,ch,idx}", name, c), 32'(o), 32'(exp_q[c]));
      @(posedge clk);
      #1;
      start = 1'b0;
      wr_en = 1'b0;
    end
    loop_drv = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      m_div[i] = 0;
      m_dur[i] = 0;
    end
    #12;
    chk("reset ch_out", 32'(ch_out), 0);
    chk("reset busy", 32'(busy), 0);
    chk("reset done", 32'(done), 0);
    chk("reset idx", 32'(idx), 0);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    run_trace("empty", 1, -1);

    wr(0, 3, 2);
    wr(1, 0, 1);
    wr(2, 2, 0);
    run_trace("melody", 1, -1);

    for (int i = 0; i < N; i++) wr(i, 1, 1);
    run_trace("wrap_inject", 1, 3);
    run_trace("wrap_replay", 1, -1);

    // Stop during the second PLAY cycle of note 0
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 stop = 1'b1;
    @(negedge clk);
    chk("pre-stop ch_out", 32'(ch_out), 1);
    chk("pre-stop busy", 32'(busy), 1);
    @(posedge clk);
    #1 stop = 1'b0;
    @(negedge clk);
    chk("stop busy", 32'(busy), 0);
    chk("stop ch_out", 32'(ch_out), 0);
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("stop no done c%0d", c), 32'(done), 0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    start = 1'b1;
    stop  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    stop  = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk($sformatf("start+stop busy c%0d", c), 32'(busy), 0);
    end
    @(posedge clk);
    #1;

    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < N; i++) begin
        wr(i, int'($urandom_range(0, 4)),
           ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 3)));
      end
      run_trace($sformatf("rand%0d", it), 1, -1);
    end

`ifdef NOTE_SEQ_LOOP_EN
    wr(0, 2, 1);
    wr(1, 0, 1);
    wr(2, 1, 1);
    wr(3, 3, 1);
    run_trace("loop4", 4, -1);
    for (int it = 0; it < 3; it++) begin
      for (int i = 0; i < N; i++) begin
        wr(i, int'($urandom_range(0, 3)), int'($urandom_range(1, 2)));
      end
      run_trace($sformatf("loop_rand%0d", it), int'($urandom_range(2, 3)), -1);
    end
`endif

    // Asynchronous reset mid-PLAY of note 1
    for (int i = 0; i < N; i++) wr(i, 1, 1);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    chk("pre-reset busy", 32'(busy), 1);
    chk("pre-reset idx", 32'(idx), 1);
    chk("pre-reset ch_out", 32'(ch_out), 1);
    #1 rstn = 1'b0;
    #1;
    chk("async reset ch_out", 32'(ch_out), 0);
    chk("async reset busy", 32'(busy), 0);
    chk("async reset done", 32'(done), 0);
    chk("async reset idx", 32'(idx), 0);
    for (int i = 0; i < N; i++) begin
      m_div[i] = 0;
      m_dur[i] = 0;
    end
    #1 rstn = 1'b1;
    @(posedge clk);
    #1;
    run_trace("post-reset empty", 1, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
